// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Shares the single register-file write port between the in-order WB stage
//   and the multi-cycle MDU. WB has priority. An MDU result that is blocked for
//   STARVE_LIMIT consecutive cycles forces one MDU write and holds WB for that
//   cycle. A scoreboard of pending MDU destinations drives the decode stall.
//
//   Optional feature macro: RFARB_PERF_CNT_EN. When defined, it adds the
//   perf_hold_cnt and perf_stall_cnt ports. These are wrapping cycle counters.
//
// Ports
//   clk, rst                       clock (rising edge); async reset, active-low
//   wb_we/wb_addr/wb_data          WB write request
//   wb_hold                        WB write not taken this cycle
//   mdu_issue/mdu_dest             MDU op issued, and its destination
//   mdu_valid/mdu_addr/mdu_data    MDU result
//   mdu_ready                      MDU result accepted this cycle
//   dec_r1/r2_addr, dec_dst_*      decode operands, checked against the scoreboard
//   dec_stall                      decode hazard on a pending MDU destination
//   rf_we/rf_waddr/rf_wdata        register-file write port
//   perf_hold_cnt, perf_stall_cnt  (RFARB_PERF_CNT_EN only) event counters
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_hold,
  input  logic              mdu_issue,
  input  logic [4:0]        mdu_dest,
  input  logic              mdu_valid,
  input  logic [4:0]        mdu_addr,
  input  logic [DATA_W-1:0] mdu_data,
  output logic              mdu_ready,
  input  logic [4:0]        dec_r1_addr,
  input  logic [4:0]        dec_r2_addr,
  input  logic              dec_dst_we,
  input  logic [4:0]        dec_dst_addr,
  output logic              dec_stall,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
`ifdef RFARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_hold_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic              grant_c;
  logic              sel_mdu_c;
  logic              mdu_ready_c;
  logic              wb_hold_c;
  logic [ADDR_W-1:0] mux_addr_c;
  logic [DATA_W-1:0] mux_data_c;
  logic              wr_en_c;

  // Grant selection and starvation tracking
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    grant_c     = 1'b0;
    sel_mdu_c   = 1'b0;
    mdu_ready_c = 1'b0;
    wb_hold_c   = 1'b0;
    case (state_q)
      S_IDLE, S_WAIT: begin
        mdu_ready_c = mdu_valid && !wb_we;
        if (wb_we) begin
          grant_c = 1'b1;
        end else if (mdu_valid) begin
          grant_c   = 1'b1;
          sel_mdu_c = 1'b1;
        end
        if (mdu_ready_c) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (state_q == S_WAIT || (mdu_valid && wb_we)) begin
          // cnt_d is the number of consecutive blocked cycles, including this one
          cnt_d   = (state_q == S_WAIT) ? cnt_q + CNT_W'(1) : CNT_W'(1);
          state_d = (cnt_d >= CNT_W'(STARVE_LIMIT)) ? S_FORCE : S_WAIT;
        end
      end
      S_FORCE: begin
        // MDU takes the port. If mdu_valid has dropped, nothing is written.
        mdu_ready_c = 1'b1;
        wb_hold_c   = wb_we;
        grant_c     = mdu_valid;
        sel_mdu_c   = 1'b1;
        state_d     = S_IDLE;
        cnt_d       = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Port mux; a write to $0 completes its handshake but is suppressed here
  always_comb begin
    mux_addr_c = sel_mdu_c ? mdu_addr : wb_addr;
    mux_data_c = sel_mdu_c ? mdu_data : wb_data;
    wr_en_c    = rst && grant_c && (mux_addr_c != '0);
  end

  // Outputs are forced low while reset is asserted
  assign mdu_ready = rst && mdu_ready_c;
  assign wb_hold   = rst && wb_hold_c;
  assign rf_we     = wr_en_c;
  assign rf_waddr  = wr_en_c ? mux_addr_c : '0;
  assign rf_wdata  = wr_en_c ? mux_data_c : '0;

  // Scoreboard update: a clear on transfer is overridden by an issue to the same register
  always_comb begin
    pending_d = pending_q;
    if (mdu_valid && mdu_ready) begin
      pending_d[mdu_addr] = 1'b0;
    end
    if (mdu_issue && (mdu_dest != '0)) begin
      pending_d[mdu_dest] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Hazard check uses the pre-update vector
  assign dec_stall = pending_q[dec_r1_addr] | pending_q[dec_r2_addr] |
                     (dec_dst_we & pending_q[dec_dst_addr]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

`ifdef RFARB_PERF_CNT_EN
  logic [31:0] perf_hold_q, perf_hold_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Wrapping event counters
  always_comb begin
    perf_hold_d  = perf_hold_q + 32'(wb_hold);
    perf_stall_d = perf_stall_q + 32'(dec_stall);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hold_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_hold_q  <= perf_hold_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_hold_cnt  = perf_hold_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter. It runs directed scenarios with literal
// expectations, then randomized traffic. A per-cycle compare process checks
// the DUT against a behavioural model.
module tb_rf_write_arbiter;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wb_we, mdu_issue, mdu_valid, dec_dst_we;
  logic [4:0]    wb_addr, mdu_dest, mdu_addr, dec_r1_addr, dec_r2_addr, dec_dst_addr;
  logic [DW-1:0] wb_data, mdu_data;
  logic          wb_hold, mdu_ready, dec_stall, rf_we;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
`ifdef RFARB_PERF_CNT_EN
  logic [31:0]   perf_hold_cnt, perf_stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Model state: consecutive blocked cycles of the current MDU result, plus the pending set
  int            m_blocked = 0;
  logic [31:0]   m_pend    = '0;
  int unsigned   m_holds   = 0;
  int unsigned   m_stalls  = 0;

  rf_write_arbiter #(.STARVE_LIMIT(LIMIT), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_hold(wb_hold),
    .mdu_issue(mdu_issue), .mdu_dest(mdu_dest),
    .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .dec_r1_addr(dec_r1_addr), .dec_r2_addr(dec_r2_addr),
    .dec_dst_we(dec_dst_we), .dec_dst_addr(dec_dst_addr), .dec_stall(dec_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
`ifdef RFARB_PERF_CNT_EN
    , .perf_hold_cnt(perf_hold_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    mdu_issue = 1'b0; mdu_dest = '0;
    mdu_valid = 1'b0; mdu_addr = '0; mdu_data = '0;
    dec_r1_addr = '0; dec_r2_addr = '0; dec_dst_we = 1'b0; dec_dst_addr = '0;
  endtask

  // Per-cycle model compare, sampled mid-cycle
  always @(negedge clk) begin : cmp
    logic          f, e_ready, e_hold, e_g, e_we, e_stall, xfer;
    logic [4:0]    e_a;
    logic [DW-1:0] e_d;
    if (!rst) begin
      chk("rst_mdu_ready", 32'(mdu_ready), 32'd0);
      chk("rst_wb_hold",   32'(wb_hold),   32'd0);
      chk("rst_dec_stall", 32'(dec_stall), 32'd0);
      chk("rst_rf_we",     32'(rf_we),     32'd0);
      chk("rst_rf_waddr",  32'(rf_waddr),  32'd0);
      chk("rst_rf_wdata",  32'(rf_wdata),  32'd0);
      m_blocked = 0;
      m_pend    = '0;
      m_holds   = 0;
      m_stalls  = 0;
    end else begin
      f   = (m_blocked >= int'(LIMIT));
      e_g = 1'b0; e_a = '0; e_d = '0;
      if (f) begin
        e_ready = 1'b1;
        e_hold  = wb_we;
        if (mdu_valid) begin e_g = 1'b1; e_a = mdu_addr; e_d = mdu_data; end
      end else begin
        e_ready = mdu_valid && !wb_we;
        e_hold  = 1'b0;
        if (wb_we)          begin e_g = 1'b1; e_a = wb_addr;  e_d = wb_data;  end
        else if (mdu_valid) begin e_g = 1'b1; e_a = mdu_addr; e_d = mdu_data; end
      end
      e_we = e_g && (e_a != 5'd0);
      if (!e_we) begin e_a = '0; e_d = '0; end
      e_stall = m_pend[dec_r1_addr] | m_pend[dec_r2_addr] | (dec_dst_we & m_pend[dec_dst_addr]);
      chk("mdu_ready", 32'(mdu_ready), 32'(e_ready));
      chk("wb_hold",   32'(wb_hold),   32'(e_hold));
      chk("dec_stall", 32'(dec_stall), 32'(e_stall));
      chk("rf_we",     32'(rf_we),     32'(e_we));
      chk("rf_waddr",  32'(rf_waddr),  32'(e_a));
      chk("rf_wdata",  32'(rf_wdata),  32'(e_d));
      m_holds  += 32'(e_hold);
      m_stalls += 32'(e_stall);
      xfer = mdu_valid && e_ready;
      if (f || xfer)                                  m_blocked = 0;
      else if (m_blocked > 0 || (mdu_valid && wb_we)) m_blocked++;
      if (xfer) m_pend[mdu_addr] = 1'b0;
      if (mdu_issue && mdu_dest != 5'd0) m_pend[mdu_dest] = 1'b1;
    end
  end

  initial begin : main
    logic keep_wb, keep_mdu;
    quiet();
    // Outputs stay at 0 during reset even with live requests
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5678; mdu_valid = 1'b1; mdu_addr = 5'd6;
    #3;
    chk("t0_rf_we", 32'(rf_we), 32'd0);
    chk("t0_mdu_ready", 32'(mdu_ready), 32'd0);
    tick(); tick();
    rst = 1'b1;
    quiet();

    // 1: WB-only write passes straight through
    tick();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hA5A5_0001;
    #3;
    chk("t1_rf_we", 32'(rf_we), 32'd1);
    chk("t1_rf_waddr", 32'(rf_waddr), 32'd5);
    chk("t1_rf_wdata", rf_wdata, 32'hA5A5_0001);
    chk("t1_wb_hold", 32'(wb_hold), 32'd0);

    // 2: contention; MDU is starved for 4 cycles, then forced
    tick();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_0055;
    mdu_valid = 1'b1; mdu_addr = 5'd7; mdu_data = 32'hDEAD_0007;
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("t2_blocked_ready", 32'(mdu_ready), 32'd0);
      chk("t2_blocked_waddr", 32'(rf_waddr), 32'd5);
      tick();
    end
    #3;
    chk("t2_force_ready", 32'(mdu_ready), 32'd1);
    chk("t2_force_hold", 32'(wb_hold), 32'd1);
    chk("t2_force_waddr", 32'(rf_waddr), 32'd7);
    chk("t2_force_wdata", rf_wdata, 32'hDEAD_0007);
    tick();
    mdu_valid = 1'b0;
    #3;
    chk("t2_wb_after_hold", 32'(wb_hold), 32'd0);
    chk("t2_wb_after_waddr", 32'(rf_waddr), 32'd5);

    // 3: scoreboard stall lifetime
    tick();
    quiet();
    mdu_issue = 1'b1; mdu_dest = 5'd9;
    tick();
    mdu_issue = 1'b0; dec_r2_addr = 5'd9;
    #3;
    chk("t3_stall_pending", 32'(dec_stall), 32'd1);
    tick();
    mdu_valid = 1'b1; mdu_addr = 5'd9; mdu_data = 32'h0000_0009;
    #3;
    chk("t3_xfer_ready", 32'(mdu_ready), 32'd1);
    chk("t3_stall_on_clear", 32'(dec_stall), 32'd1);
    tick();
    mdu_valid = 1'b0;
    #3;
    chk("t3_stall_after", 32'(dec_stall), 32'd0);

    // 4: register $0
    tick();
    quiet();
    mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'hFFFF_FFFF;
    #3;
    chk("t4_zero_ready", 32'(mdu_ready), 32'd1);
    chk("t4_zero_we", 32'(rf_we), 32'd0);
    tick();
    mdu_valid = 1'b0; mdu_issue = 1'b1; mdu_dest = 5'd0;
    tick();
    mdu_issue = 1'b0; dec_dst_we = 1'b1;
    #3;
    chk("t4_zero_stall", 32'(dec_stall), 32'd0);

    // 5: issue and completion to the same register in one cycle; set wins
    tick();
    quiet();
    mdu_issue = 1'b1; mdu_dest = 5'd3;
    tick();
    mdu_valid = 1'b1; mdu_addr = 5'd3; mdu_data = 32'h0000_0003;
    #3;
    chk("t5_ready", 32'(mdu_ready), 32'd1);
    tick();
    quiet();
    dec_r1_addr = 5'd3;
    #3;
    chk("t5_still_pending", 32'(dec_stall), 32'd1);

    // 6: reset while in WAIT with register 8 pending
    tick();
    quiet();
    mdu_issue = 1'b1; mdu_dest = 5'd8;
    wb_we = 1'b1; wb_addr = 5'd1; mdu_valid = 1'b1; mdu_addr = 5'd4;
    tick();
    mdu_issue = 1'b0; dec_r1_addr = 5'd8;
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_stall", 32'(dec_stall), 32'd0);
    chk("t6_rst_we", 32'(rf_we), 32'd0);
    tick();
    rst = 1'b1;
    #3;
    chk("t6_post_stall", 32'(dec_stall), 32'd0);
    chk("t6_post_ready", 32'(mdu_ready), 32'd0);
    chk("t6_post_waddr", 32'(rf_waddr), 32'd1);
    tick();
    wb_we = 1'b0;
    tick();
    quiet();

    // Random traffic that obeys the hold/valid protocol
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      keep_wb  = wb_we && wb_hold;
      keep_mdu = mdu_valid && !mdu_ready;
      tick();
      if (!keep_wb) begin
        wb_we   = ($urandom_range(0, 99) < 60);
        wb_addr = 5'($urandom_range(0, 7));
        wb_data = $urandom;
      end
      if (!keep_mdu) begin
        mdu_valid = ($urandom_range(0, 99) < 40);
        mdu_addr  = 5'($urandom_range(0, 7));
        mdu_data  = $urandom;
      end
      mdu_issue    = ($urandom_range(0, 99) < 20);
      mdu_dest     = 5'($urandom_range(0, 7));
      dec_r1_addr  = 5'($urandom_range(0, 7));
      dec_r2_addr  = 5'($urandom_range(0, 7));
      dec_dst_we   = $urandom_range(0, 1) == 1;
      dec_dst_addr = 5'($urandom_range(0, 7));
    end

    tick();
    quiet();
    @(negedge clk);
    tick();
`ifdef RFARB_PERF_CNT_EN
    chk("perf_hold_cnt", perf_hold_cnt, m_holds);
    chk("perf_stall_cnt", perf_stall_cnt, m_stalls);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
